// File: rtl/nmea_pkg.sv
// Shared types, ASCII constants and the hex-digit decoder for the NMEA
// sentence framer.
package nmea_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BODY   = 3'd1,
    CK_HI  = 3'd2,
    CK_LO  = 3'd3,
    EOL_CR = 3'd4,
    EOL_LF = 3'd5,
    REPLAY = 3'd6
  } framer_state_t;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_digit_t;

  // Decode one ASCII hex digit (0-9, A-F, a-f); valid=0 for anything else.
  function automatic hex_digit_t hex_decode(input logic [7:0] ch);
    hex_digit_t r;
    r.valid  = 1'b0;
    r.nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      r.valid  = 1'b1;
      r.nibble = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them to 10.
      r.valid  = 1'b1;
      r.nibble = ch[3:0] + 4'd9;
    end else begin
      r.valid  = 1'b0;
      r.nibble = 4'h0;
    end
    return r;
  endfunction

endpackage

// File: rtl/nmea_line_buffer.sv
// Sentence storage: simple dual-port RAM, DEPTH x 8, synchronous write and
// synchronous read on one clock. The read register is cleared by reset so
// the replay data output starts at zero.
module nmea_line_buffer #(
  parameter int DEPTH = 80,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port: store one sentence byte.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: registered read, holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/nmea_sentence_framer.sv
// NMEA sentence framer: collects $...*HH<CR><LF> sentences from the UART
// byte stream, verifies the XOR checksum and replays valid sentences over a
// valid/ready stream. Define NMEA_FRAMER_STATS_EN to build the saturating
// discarded-sentence counter; otherwise err_count is tied to zero.
module nmea_sentence_framer
  import nmea_pkg::*;
#(
  parameter int MAX_LEN = 80,
  parameter int CNT_W   = 16
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             sentence_ok,
  output logic             sentence_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam logic [IW-1:0] FULL_IDX = IW'(MAX_LEN);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  framer_state_t state;
  logic [IW-1:0] widx;
  logic [IW-1:0] len;
  logic [IW-1:0] rd_addr;
  logic [7:0]    xor_acc;
  logic [7:0]    ck_val;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rd_en;
  hex_digit_t    hex;
  logic          is_dollar;

  assign hex       = hex_decode(rx_data);
  assign is_dollar = (rx_data == ASCII_DOLLAR);
  // Fetch the next byte whenever the output register is empty or draining.
  assign rd_en     = (state == REPLAY) && (rd_addr < len) && (!out_valid || out_ready);

  nmea_line_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (sclk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr[AW-1:0]),
    .rdata (out_data)
  );

  // Framing FSM: collection, checksum validation and replay sequencing.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state        <= IDLE;
      widx         <= {IW{1'b0}};
      len          <= {IW{1'b0}};
      rd_addr      <= {IW{1'b0}};
      xor_acc      <= 8'h00;
      ck_val       <= 8'h00;
      wr_en        <= 1'b0;
      wr_addr      <= {AW{1'b0}};
      wr_data      <= 8'h00;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      sentence_ok  <= 1'b0;
      sentence_err <= 1'b0;
    end else begin
      wr_en        <= 1'b0;
      wr_addr      <= widx[AW-1:0];
      wr_data      <= rx_data;
      sentence_ok  <= 1'b0;
      sentence_err <= 1'b0;
      if (rx_valid && is_dollar && state != IDLE && state != REPLAY) begin
        // Resync: drop the partial sentence and restart with this '$'.
        sentence_err <= 1'b1;
        wr_en        <= 1'b1;
        wr_addr      <= {AW{1'b0}};
        widx         <= ONE_IDX;
        xor_acc      <= 8'h00;
        state        <= BODY;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid && is_dollar) begin
              wr_en   <= 1'b1;
              wr_addr <= {AW{1'b0}};
              widx    <= ONE_IDX;
              xor_acc <= 8'h00;
              state   <= BODY;
            end
          end
          BODY: begin
            if (rx_valid) begin
              if (widx == FULL_IDX) begin
                sentence_err <= 1'b1;
                state        <= IDLE;
              end else begin
                wr_en <= 1'b1;
                widx  <= widx + ONE_IDX;
                if (rx_data == ASCII_STAR) begin
                  state <= CK_HI;
                end else begin
                  xor_acc <= xor_acc ^ rx_data;
                end
              end
            end
          end
          CK_HI, CK_LO: begin
            if (rx_valid) begin
              if (!hex.valid || widx == FULL_IDX) begin
                sentence_err <= 1'b1;
                state        <= IDLE;
              end else begin
                wr_en <= 1'b1;
                widx  <= widx + ONE_IDX;
                if (state == CK_HI) begin
                  ck_val[7:4] <= hex.nibble;
                  state       <= CK_LO;
                end else begin
                  ck_val[3:0] <= hex.nibble;
                  state       <= EOL_CR;
                end
              end
            end
          end
          EOL_CR: begin
            if (rx_valid) begin
              if (rx_data == ASCII_CR) begin
                state <= EOL_LF;
              end else begin
                sentence_err <= 1'b1;
                state        <= IDLE;
              end
            end
          end
          EOL_LF: begin
            if (rx_valid) begin
              if (rx_data == ASCII_LF && ck_val == xor_acc) begin
                sentence_ok <= 1'b1;
                len         <= widx;
                rd_addr     <= {IW{1'b0}};
                state       <= REPLAY;
              end else begin
                sentence_err <= 1'b1;
                state        <= IDLE;
              end
            end
          end
          REPLAY: begin
            // Incoming bytes are ignored here; the buffer is being read out.
            if (rd_en) begin
              rd_addr   <= rd_addr + ONE_IDX;
              out_valid <= 1'b1;
              out_last  <= (rd_addr == (len - ONE_IDX));
            end else if (out_valid && out_ready) begin
              // Final byte accepted and nothing left to fetch.
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef NMEA_FRAMER_STATS_EN
  // Saturating count of discarded sentences.
  always_ff @(posedge sclk) begin
    if (rst) begin
      err_count <= {CNT_W{1'b0}};
    end else if (sentence_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  assign err_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_nmea_sentence_framer.sv
// Self-checking bench for nmea_sentence_framer: directed sentences, replay
// bytes checked against a scoreboard queue, pulse/counter bookkeeping.
module tb_nmea_sentence_framer;

`ifdef NMEA_FRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        sclk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        sentence_ok;
  logic        sentence_err;
  logic [15:0] err_count;

  int compared   = 0;
  int mismatched = 0;
  int ok_seen    = 0;
  int err_seen   = 0;
  int exp_ok     = 0;
  int exp_err    = 0;
  int err_base   = 0;

  logic [8:0] sb[$];
  logic       stalled_prev = 1'b0;
  logic [7:0] held         = 8'h00;

  always #5 sclk = ~sclk;

  nmea_sentence_framer #(.MAX_LEN(80), .CNT_W(16)) dut (
    .sclk         (sclk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .sentence_ok  (sentence_ok),
    .sentence_err (sentence_err),
    .err_count    (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: scoreboard pops, stall hold, pulse counts.
  always @(negedge sclk) begin
    if (!rst) begin
      if (sentence_ok)  ok_seen++;
      if (sentence_err) err_seen++;
      if (out_last) check("last_needs_valid", {31'd0, out_valid}, 32'd1);
      if (stalled_prev && out_valid) check("stall_hold", {24'd0, out_data}, {24'd0, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_xfer", sb.size(), 32'd1);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          check("replay_data", {24'd0, out_data}, {24'd0, e[7:0]});
          check("replay_last", {31'd0, out_last}, {31'd0, e[8]});
        end
      end
      stalled_prev = out_valid && !out_ready;
      held         = out_data;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge sclk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_sentence(input string s);
    send_str(s);
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) sb.push_back({(i == s.len() - 1), s[i]});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      idle(1);
    end
    check(tag, sb.size(), 32'd0);
    idle(2);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ok"},  ok_seen,  exp_ok);
    check({tag, "_err"}, err_seen, exp_err);
    check({tag, "_cnt"}, {16'd0, err_count}, STATS ? (exp_err - err_base) : 0);
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b1;
    idle(3);
    check("rst_out_valid", {31'd0, out_valid},    32'd0);
    check("rst_out_last",  {31'd0, out_last},     32'd0);
    check("rst_out_data",  {24'd0, out_data},     32'd0);
    check("rst_ok",        {31'd0, sentence_ok},  32'd0);
    check("rst_err",       {31'd0, sentence_err}, 32'd0);
    check("rst_err_count", {16'd0, err_count},    32'd0);
    rst = 1'b0;
    idle(2);

    // Basic valid sentence with latency checks.
    expect_str("$AB*03");
    send_str("$AB*03");
    send_byte(8'h0D);
    send_byte(8'h0A);
    check("ok_at_n1",    {31'd0, sentence_ok}, 32'd1);
    check("valid_at_n1", {31'd0, out_valid},   32'd0);
    idle(1);
    check("valid_at_n2", {31'd0, out_valid},   32'd1);
    check("first_dollar", {24'd0, out_data},   32'h24);
    exp_ok++;
    wait_drain("drain_basic", 40);
    check_counts("basic");

    // Bad checksum: dropped, no output.
    send_sentence("$AB*04");
    idle(4);
    exp_err++;
    check("badck_no_valid", {31'd0, out_valid}, 32'd0);
    check_counts("badck");

    // Lowercase hex digits.
    expect_str("$Z*5a");
    send_sentence("$Z*5a");
    exp_ok++;
    wait_drain("drain_lower", 40);
    check_counts("lower");

    // Resync on '$' mid-sentence.
    expect_str("$AB*03");
    send_sentence("$AB$AB*03");
    exp_err++;
    exp_ok++;
    wait_drain("drain_resync", 40);
    check_counts("resync");

    // Overflow: '$' + 79 'A' fill indices 0..79, the next byte overflows.
    send_byte(8'h24);
    for (int i = 0; i < 79; i++) send_byte(8'h41);
    send_byte(8'h41);
    check("ovf_err_pulse", {31'd0, sentence_err}, 32'd1);
    for (int i = 0; i < 9; i++) send_byte(8'h41);
    idle(3);
    exp_err++;
    check_counts("ovf");
    expect_str("$AB*03");
    send_sentence("$AB*03");
    exp_ok++;
    wait_drain("drain_after_ovf", 40);
    check_counts("after_ovf");

    // Back-pressure with a full sentence arriving during replay (dropped).
    expect_str("$AB*03");
    send_sentence("$AB*03");
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          out_ready = (i % 2 == 1);
          idle(1);
        end
        out_ready = 1'b1;
      end
      begin
        send_sentence("$AB*03");
      end
    join
    exp_ok++;
    wait_drain("drain_bp", 60);
    idle(4);
    check_counts("bp");

    // Reset in the middle of a stalled replay.
    out_ready = 1'b0;
    send_sentence("$AB*03");
    idle(1);
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    exp_ok++;
    rst = 1'b1;
    idle(1);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    err_base  = exp_err;
    idle(4);
    check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    check_counts("midrst");
    expect_str("$Z*5a");
    send_sentence("$Z*5a");
    exp_ok++;
    wait_drain("drain_recover", 40);
    check_counts("recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
